// File: rtl/burst_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : burst_arbiter
//  Description : Two-slave round-robin burst arbiter. Grants one slave per
//                burst, forwards its words one per cycle to the processing
//                engine with FIFO backpressure, then waits for the engine to
//                signal completion before arbitrating again.
//  Revision    : 1.0  initial release
// ============================================================================
module burst_arbiter #(
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [1:0]    slv0_mode,
   input  logic [1:0]    slv1_mode,
   input  logic          slv0_data_valid,
   input  logic          slv1_data_valid,
   input  logic [7:0]    slv0_proc_valid,
   input  logic [7:0]    slv1_proc_valid,
   input  logic [DW-1:0] slv0_data,
   input  logic [DW-1:0] slv1_data,
   input  logic          proc_cmplt,
   input  logic          fifo_full,
   output logic [1:0]    slvx_mode,
   output logic          slvx_data_valid,
   output logic [7:0]    slvx_proc_val,
   output logic [DW-1:0] slvx_data,
   output logic          slv0_ready,
   output logic          slv1_ready,
   output logic          data_source,
   output logic          mstr0_cmplt
);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      XFER       = 2'd1,
      WAIT_CMPLT = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_next_state;
   logic [7:0]      r_count;
   logic            r_last_grant;
   logic            w_req0;
   logic            w_req1;
   logic            w_grant;
   logic            w_grant_sel;
   logic            w_accept;
   logic            w_done;
   logic [DW-1:0]   w_word;

   // The word on offer always comes from the slave that owns the burst.
   assign w_word = data_source ? slv1_data : slv0_data;

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state decode, arbitration and combinational ready strobes.
   always_comb begin
      w_next_state = r_state;
      w_req0       = slv0_data_valid && (slv0_proc_valid != 8'd0);
      w_req1       = slv1_data_valid && (slv1_proc_valid != 8'd0);
      w_grant      = 1'b0;
      w_grant_sel  = 1'b0;
      w_accept     = 1'b0;
      w_done       = 1'b0;
      slv0_ready   = 1'b0;
      slv1_ready   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_req0 || w_req1) begin
               w_grant      = 1'b1;
               // On a tie the slave that did not finish the last burst wins.
               w_grant_sel  = (w_req0 && w_req1) ? ~r_last_grant : w_req1;
               w_next_state = XFER;
            end
         end
         XFER: begin
            slv0_ready = !data_source && !fifo_full;
            slv1_ready = data_source && !fifo_full;
            w_accept   = (slv0_ready && slv0_data_valid) ||
                         (slv1_ready && slv1_data_valid);
            if (w_accept && (r_count == 8'd1)) begin
               w_next_state = WAIT_CMPLT;
            end
         end
         WAIT_CMPLT: begin
            if (proc_cmplt) begin
               w_done       = 1'b1;
               w_next_state = IDLE;
            end
         end
         default: begin
            w_next_state = IDLE;
         end
      endcase
   end

   // Burst attribute latching, word forwarding, countdown and completion pulse.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_count         <= 8'd0;
         r_last_grant    <= 1'b1;
         data_source     <= 1'b0;
         slvx_mode       <= 2'd0;
         slvx_proc_val   <= 8'd0;
         slvx_data       <= '0;
         slvx_data_valid <= 1'b0;
         mstr0_cmplt     <= 1'b0;
      end else begin
         slvx_data_valid <= w_accept;
         mstr0_cmplt     <= w_done;
         if (w_grant) begin
            data_source   <= w_grant_sel;
            slvx_mode     <= w_grant_sel ? slv1_mode : slv0_mode;
            slvx_proc_val <= w_grant_sel ? slv1_proc_valid : slv0_proc_valid;
            r_count       <= w_grant_sel ? slv1_proc_valid : slv0_proc_valid;
         end
         if (w_accept) begin
            slvx_data <= w_word;
            r_count   <= r_count - 8'd1;
         end
         if (w_done) begin
            r_last_grant <= data_source;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_burst_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_burst_arbiter
//  Description : Directed self-checking bench for burst_arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_burst_arbiter;

   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [1:0]    slv0_mode, slv1_mode;
   logic          slv0_data_valid, slv1_data_valid;
   logic [7:0]    slv0_proc_valid, slv1_proc_valid;
   logic [DW-1:0] slv0_data, slv1_data;
   logic          proc_cmplt, fifo_full;
   logic [1:0]    slvx_mode;
   logic          slvx_data_valid;
   logic [7:0]    slvx_proc_val;
   logic [DW-1:0] slvx_data;
   logic          slv0_ready, slv1_ready, data_source, mstr0_cmplt;

   int vectors     = 0;
   int miscompares = 0;

   burst_arbiter #(.DW(DW)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .slv0_mode       (slv0_mode),
      .slv1_mode       (slv1_mode),
      .slv0_data_valid (slv0_data_valid),
      .slv1_data_valid (slv1_data_valid),
      .slv0_proc_valid (slv0_proc_valid),
      .slv1_proc_valid (slv1_proc_valid),
      .slv0_data       (slv0_data),
      .slv1_data       (slv1_data),
      .proc_cmplt      (proc_cmplt),
      .fifo_full       (fifo_full),
      .slvx_mode       (slvx_mode),
      .slvx_data_valid (slvx_data_valid),
      .slvx_proc_val   (slvx_proc_val),
      .slvx_data       (slvx_data),
      .slv0_ready      (slv0_ready),
      .slv1_ready      (slv1_ready),
      .data_source     (data_source),
      .mstr0_cmplt     (mstr0_cmplt)
   );

   always #5 clk = ~clk;

   // Global time bound.
   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200000");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] word(input logic src, input int k);
      return 32'h5A00_0000 | (32'(src) << 16) | 32'(k);
   endfunction

   task automatic clear_slaves();
      slv0_mode = 2'd0; slv1_mode = 2'd0;
      slv0_data_valid = 1'b0; slv1_data_valid = 1'b0;
      slv0_proc_valid = 8'd0; slv1_proc_valid = 8'd0;
      slv0_data = '0; slv1_data = '0;
      proc_cmplt = 1'b0; fifo_full = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_mode"},   64'(slvx_mode), 64'd0);
      check({tag, "_len"},    64'(slvx_proc_val), 64'd0);
      check({tag, "_data"},   64'(slvx_data), 64'd0);
      check({tag, "_src"},    64'(data_source), 64'd0);
      check({tag, "_valid"},  64'(slvx_data_valid), 64'd0);
      check({tag, "_cmplt"},  64'(mstr0_cmplt), 64'd0);
      check({tag, "_rdy0"},   64'(slv0_ready), 64'd0);
      check({tag, "_rdy1"},   64'(slv1_ready), 64'd0);
   endtask

   // One full burst from the grant edge to the completion pulse. Requests are
   // already set up by the caller; this drives the granted slave's words.
   task automatic burst(input logic src, input logic [1:0] mode, input logic [7:0] len,
                        input int stall_at, input int stall_n, input bit mode_change);
      int acc    = 0;
      int cyc    = 0;
      int stalls = stall_n;
      bit rdy;
      tick();
      check("grant_src",  64'(data_source), 64'(src));
      check("grant_mode", 64'(slvx_mode), 64'(mode));
      check("grant_len",  64'(slvx_proc_val), 64'(len));
      while (acc < int'(len) && cyc < 64) begin
         if (src) slv1_data = word(src, acc); else slv0_data = word(src, acc);
         fifo_full = (acc == stall_at) && (stalls > 0);
         if (fifo_full) stalls--;
         rdy = !fifo_full;
         if (mode_change && acc >= 1) begin
            if (src) begin slv1_mode = mode ^ 2'b01; slv1_proc_valid = 8'hFF; end
            else     begin slv0_mode = mode ^ 2'b01; slv0_proc_valid = 8'hFF; end
         end
         #1;
         check("ready_granted", 64'(src ? slv1_ready : slv0_ready), 64'(rdy));
         check("ready_other",   64'(src ? slv0_ready : slv1_ready), 64'd0);
         tick();
         if (rdy) begin
            check("word_valid", 64'(slvx_data_valid), 64'd1);
            check("word_data",  64'(slvx_data), 64'(word(src, acc)));
            acc++;
         end else begin
            check("stall_valid", 64'(slvx_data_valid), 64'd0);
            if (acc > 0) check("stall_hold", 64'(slvx_data), 64'(word(src, acc - 1)));
         end
         check("hold_mode", 64'(slvx_mode), 64'(mode));
         check("hold_len",  64'(slvx_proc_val), 64'(len));
         cyc++;
      end
      check("burst_words", 64'(acc), 64'(len));
      fifo_full = 1'b0;
      #1;
      check("wait_ready", 64'(src ? slv1_ready : slv0_ready), 64'd0);
      tick();
      check("wait_valid",    64'(slvx_data_valid), 64'd0);
      check("wait_no_cmplt", 64'(mstr0_cmplt), 64'd0);
      proc_cmplt = 1'b1;
      tick();
      proc_cmplt = 1'b0;
      check("cmplt_pulse", 64'(mstr0_cmplt), 64'd1);
      check("cmplt_src",   64'(data_source), 64'(src));
   endtask

   initial begin
      rst_n = 1'b0;
      clear_slaves();
      tick();
      tick();
      check_all_zero("reset");
      rst_n = 1'b1;

      // Completion strobe while idle has no effect.
      proc_cmplt = 1'b1;
      tick();
      proc_cmplt = 1'b0;
      check("idle_cmplt_ignored", 64'(mstr0_cmplt), 64'd0);
      tick();
      check("idle_no_valid", 64'(slvx_data_valid), 64'd0);

      // Slave 0 alone, 4 words, no backpressure.
      slv0_mode = 2'd1; slv0_proc_valid = 8'd4; slv0_data_valid = 1'b1;
      burst(1'b0, 2'd1, 8'd4, -1, 0, 1'b0);
      clear_slaves();
      tick();
      check("cmplt_one_cycle", 64'(mstr0_cmplt), 64'd0);

      // Ties from reset: 0, then 1, then 0.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      slv0_mode = 2'd1; slv1_mode = 2'd2;
      slv0_proc_valid = 8'd2; slv1_proc_valid = 8'd2;
      slv0_data_valid = 1'b1; slv1_data_valid = 1'b1;
      burst(1'b0, 2'd1, 8'd2, -1, 0, 1'b0);
      burst(1'b1, 2'd2, 8'd2, -1, 0, 1'b0);
      burst(1'b0, 2'd1, 8'd2, -1, 0, 1'b0);
      clear_slaves();
      tick();

      // Backpressure for 3 cycles in a 4-word burst.
      slv0_mode = 2'd0; slv0_proc_valid = 8'd4; slv0_data_valid = 1'b1;
      burst(1'b0, 2'd0, 8'd4, 1, 3, 1'b0);
      clear_slaves();
      tick();

      // Mode/length changes mid-burst are ignored.
      slv0_mode = 2'd2; slv0_proc_valid = 8'd3; slv0_data_valid = 1'b1;
      burst(1'b0, 2'd2, 8'd3, -1, 0, 1'b1);
      clear_slaves();
      tick();

      // Slave 1 valid with zero length never wins.
      slv1_data_valid = 1'b1; slv1_proc_valid = 8'd0; slv1_mode = 2'd3;
      slv0_mode = 2'd1; slv0_proc_valid = 8'd2; slv0_data_valid = 1'b1;
      burst(1'b0, 2'd1, 8'd2, -1, 0, 1'b0);
      slv0_data_valid = 1'b0; slv0_proc_valid = 8'd0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("zero_len_rdy1",  64'(slv1_ready), 64'd0);
         check("zero_len_src",   64'(data_source), 64'd0);
         check("zero_len_valid", 64'(slvx_data_valid), 64'd0);
      end
      clear_slaves();

      // Reset at word 2 of a 5-word burst.
      slv0_mode = 2'd1; slv0_proc_valid = 8'd5; slv0_data_valid = 1'b1;
      slv0_data = word(1'b0, 0);
      tick();
      check("abort_grant_len", 64'(slvx_proc_val), 64'd5);
      tick();
      slv0_data = word(1'b0, 1);
      tick();
      check("abort_word1", 64'(slvx_data), 64'(word(1'b0, 1)));
      slv0_data = word(1'b0, 2);
      rst_n = 1'b0;
      tick();
      check_all_zero("abort");
      rst_n = 1'b1;
      clear_slaves();
      tick();
      check("abort_no_cmplt", 64'(mstr0_cmplt), 64'd0);

      // Single-word bursts on a tie right after reset: slave 0 first.
      slv0_mode = 2'd3; slv1_mode = 2'd2;
      slv0_proc_valid = 8'd1; slv1_proc_valid = 8'd1;
      slv0_data_valid = 1'b1; slv1_data_valid = 1'b1;
      burst(1'b0, 2'd3, 8'd1, -1, 0, 1'b0);
      burst(1'b1, 2'd2, 8'd1, -1, 0, 1'b0);
      clear_slaves();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
